// File: rtl/nn_mem_ctrl.sv
// nn_mem_ctrl: load sequencer and mem_sys port arbiter for the NN accelerator.
// Streams a 1-bit load into four weight banks and input bank 0, then hands the
// mem_sys port to the compute module until it reports completion.
// Optional feature: define NN_MEM_CTRL_LOAD_CHECKSUM_EN to count loaded 1-bits.
module nn_mem_ctrl #(
    parameter int unsigned W_ADDR_LEN = 20,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_SEL_LEN  = 2,
    parameter int unsigned X_SEL_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_ADDR_LEN-1:0] len_w,
    input  logic [X_ADDR_LEN-1:0] len_x,
    input  logic                  in_valid,
    input  logic                  in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  we_w,
    output logic [W_ADDR_LEN-1:0] address_w,
    output logic [W_SEL_LEN-1:0]  sel_w,
    output logic                  we_x,
    output logic [X_ADDR_LEN-1:0] address_x,
    output logic [X_SEL_LEN-1:0]  sel_x,
    output logic                  data_in,
    input  logic                  cmp_we_w,
    input  logic [W_ADDR_LEN-1:0] cmp_address_w,
    input  logic [W_SEL_LEN-1:0]  cmp_sel_w,
    input  logic                  cmp_we_x,
    input  logic [X_ADDR_LEN-1:0] cmp_address_x,
    input  logic [X_SEL_LEN-1:0]  cmp_sel_x,
    input  logic                  cmp_data_in,
    output logic                  cmp_start,
    input  logic                  cmp_done,
    output logic [23:0]           load_ones
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_FLUSH, S_COMPUTE, S_DONE
    } state_t;

    state_t state, state_n;

    logic [W_ADDR_LEN-1:0] len_w_q;
    logic [X_ADDR_LEN-1:0] len_x_q;
    logic [W_ADDR_LEN-1:0] idx;
    logic [W_SEL_LEN-1:0]  bsel;
    logic                  owner_cmp;
    logic                  first_cmp;

    logic                  wr_we_w;
    logic                  wr_we_x;
    logic                  wr_data;
    logic [W_ADDR_LEN-1:0] wr_addr_w;
    logic [W_SEL_LEN-1:0]  wr_sel_w;
    logic [X_ADDR_LEN-1:0] wr_addr_x;

    logic loading;
    logic accept;
    logic bank_end;
    logic last_w;
    logic last_x;

    assign loading  = (state == S_LOAD_W) || (state == S_LOAD_X);
    assign accept   = loading && in_valid;
    assign bank_end = (idx == len_w_q - W_ADDR_LEN'(1));
    assign last_w   = bank_end && (bsel == {W_SEL_LEN{1'b1}});
    assign last_x   = (idx == W_ADDR_LEN'(len_x_q) - W_ADDR_LEN'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; empty load phases are skipped
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_w != '0)      state_n = S_LOAD_W;
                    else if (len_x != '0) state_n = S_LOAD_X;
                    else                  state_n = S_FLUSH;
                end
            end
            S_LOAD_W: begin
                if (accept && last_w) state_n = (len_x_q != '0) ? S_LOAD_X : S_FLUSH;
            end
            S_LOAD_X: begin
                if (accept && last_x) state_n = S_FLUSH;
            end
            S_FLUSH:   state_n = S_COMPUTE;
            S_COMPUTE: if (cmp_done) state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Owner and compute-grant registers track entry into COMPUTE
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_cmp <= 1'b0;
            first_cmp <= 1'b0;
        end else begin
            owner_cmp <= (state_n == S_COMPUTE);
            first_cmp <= (state == S_FLUSH);
        end
    end

    // Length capture, bank/address counters and the one-deep write register
    always_ff @(posedge clk) begin
        if (rst) begin
            len_w_q   <= '0;
            len_x_q   <= '0;
            idx       <= '0;
            bsel      <= '0;
            wr_we_w   <= 1'b0;
            wr_we_x   <= 1'b0;
            wr_data   <= 1'b0;
            wr_addr_w <= '0;
            wr_sel_w  <= '0;
            wr_addr_x <= '0;
        end else begin
            wr_we_w   <= 1'b0;
            wr_we_x   <= 1'b0;
            wr_data   <= 1'b0;
            wr_addr_w <= '0;
            wr_sel_w  <= '0;
            wr_addr_x <= '0;
            if ((state == S_IDLE) && start) begin
                len_w_q <= len_w;
                len_x_q <= len_x;
                idx     <= '0;
                bsel    <= '0;
            end else if (accept) begin
                wr_data <= in_data;
                if (state == S_LOAD_W) begin
                    wr_we_w   <= 1'b1;
                    wr_addr_w <= idx;
                    wr_sel_w  <= bsel;
                    if (bank_end) begin
                        idx  <= '0;
                        bsel <= bsel + W_SEL_LEN'(1);
                    end else begin
                        idx <= idx + W_ADDR_LEN'(1);
                    end
                end else begin
                    wr_we_x   <= 1'b1;
                    wr_addr_x <= X_ADDR_LEN'(idx);
                    idx       <= idx + W_ADDR_LEN'(1);
                end
            end
        end
    end

`ifdef NN_MEM_CTRL_LOAD_CHECKSUM_EN
    // Saturating count of accepted 1-bits, cleared on each new sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ones <= '0;
        end else if ((state == S_IDLE) && start) begin
            load_ones <= '0;
        end else if (accept && in_data && (load_ones != 24'hFF_FFFF)) begin
            load_ones <= load_ones + 24'(1);
        end
    end
`else
    assign load_ones = '0;
`endif

    // Status outputs and mem_sys port mux by owner
    always_comb begin
        in_ready  = loading;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        cmp_start = first_cmp && (state == S_COMPUTE);
        we_w      = wr_we_w;
        address_w = wr_addr_w;
        sel_w     = wr_sel_w;
        we_x      = wr_we_x;
        address_x = wr_addr_x;
        sel_x     = '0;
        data_in   = wr_data;
        if (owner_cmp) begin
            we_w      = cmp_we_w;
            address_w = cmp_address_w;
            sel_w     = cmp_sel_w;
            we_x      = cmp_we_x;
            address_x = cmp_address_x;
            sel_x     = cmp_sel_x;
            data_in   = cmp_data_in;
        end
    end

endmodule

// File: tb/tb_nn_mem_ctrl.sv
// Randomized bench for nn_mem_ctrl: expected writes are derived from beat
// numbers (bank = n / len_w, address = n % len_w), not from controller state.
module tb_nn_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_data;
    logic [19:0] len_w;
    logic [9:0]  len_x;
    logic        in_ready, busy, done;
    logic        we_w, we_x, data_in;
    logic [19:0] address_w;
    logic [1:0]  sel_w, sel_x;
    logic [9:0]  address_x;
    logic        cmp_we_w, cmp_we_x, cmp_data_in, cmp_start, cmp_done;
    logic [19:0] cmp_address_w;
    logic [1:0]  cmp_sel_w, cmp_sel_x;
    logic [9:0]  cmp_address_x;
    logic [23:0] load_ones;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nn_mem_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len_w(len_w), .len_x(len_x),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done),
        .we_w(we_w), .address_w(address_w), .sel_w(sel_w),
        .we_x(we_x), .address_x(address_x), .sel_x(sel_x), .data_in(data_in),
        .cmp_we_w(cmp_we_w), .cmp_address_w(cmp_address_w), .cmp_sel_w(cmp_sel_w),
        .cmp_we_x(cmp_we_x), .cmp_address_x(cmp_address_x), .cmp_sel_x(cmp_sel_x),
        .cmp_data_in(cmp_data_in), .cmp_start(cmp_start), .cmp_done(cmp_done),
        .load_ones(load_ones)
    );

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [36:0] mem_vec();
        return {we_w, address_w, sel_w, we_x, address_x, sel_x, data_in};
    endfunction

    function automatic logic [36:0] cmp_vec();
        return {cmp_we_w, cmp_address_w, cmp_sel_w, cmp_we_x, cmp_address_x, cmp_sel_x, cmp_data_in};
    endfunction

    // Write expected for the n-th accepted beat of a sequence
    function automatic logic [36:0] exp_write(input int lw, input int n, input logic d);
        if (n < 4 * lw)
            return {1'b1, 20'(n % lw), 2'(n / lw), 1'b0, 10'd0, 2'd0, d};
        return {1'b0, 20'd0, 2'd0, 1'b1, 10'(n - 4 * lw), 2'd0, d};
    endfunction

    task automatic rand_cmp();
        cmp_we_w      = 1'($urandom);
        cmp_address_w = 20'($urandom);
        cmp_sel_w     = 2'($urandom);
        cmp_we_x      = 1'($urandom);
        cmp_address_x = 10'($urandom);
        cmp_sel_x     = 2'($urandom);
        cmp_data_in   = 1'($urandom);
    endtask

    // One full sequence: start, load (valid pattern by vmode), flush, compute, done
    task automatic run_seq(input int lw, input int lx, input int vmode);
        int          total;
        int          n;
        int          ones;
        int          cyc;
        int          ncmp;
        logic [36:0] pend;
        logic        v;
        total = 4 * lw + lx;
        n = 0; ones = 0; cyc = 0; pend = '0;

        @(posedge clk); #1;
        start = 1'b1; len_w = 20'(lw); len_x = 10'(lx); in_valid = 1'b0; cmp_done = 1'b0;
        rand_cmp();
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_ready", 64'(in_ready), 64'(0));
        check("idle_mem", 64'(mem_vec()), 64'(0));

        @(posedge clk); #1;
        while (n < total && cyc < 2000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = 1'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            len_w    = 20'($urandom_range(0, 3));
            len_x    = 10'($urandom_range(0, 3));
            cmp_done = 1'($urandom);
            rand_cmp();
            @(negedge clk);
            check("ld_ready", 64'(in_ready), 64'(1));
            check("ld_busy", 64'(busy), 64'(1));
            check("ld_write", 64'(mem_vec()), 64'(pend));
            check("ld_flags", 64'({done, cmp_start}), 64'(0));
            pend = v ? exp_write(lw, n, in_data) : 37'd0;
            if (v) begin
                ones += int'(in_data);
                n++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        check("ld_budget", 64'(n), 64'(total));

        // FLUSH: last write visible, no further beats taken, early cmp_done ignored
        start = 1'b0; in_valid = 1'b1; in_data = 1'($urandom); cmp_done = 1'b1;
        rand_cmp();
        @(negedge clk);
        check("fl_ready", 64'(in_ready), 64'(0));
        check("fl_busy", 64'(busy), 64'(1));
        check("fl_write", 64'(mem_vec()), 64'(pend));
        check("fl_cmp_start", 64'(cmp_start), 64'(0));

        // First COMPUTE cycle: grant pulse and pass-through together
        @(posedge clk); #1;
        cmp_done = 1'b0; in_valid = 1'($urandom);
        rand_cmp();
        cmp_we_w = 1'b1; cmp_address_w = 20'h12345; cmp_sel_w = 2'd2;
        @(negedge clk);
        check("cp_start", 64'(cmp_start), 64'(1));
        check("cp_pass0", 64'(mem_vec()), 64'(cmp_vec()));
        check("cp_ready", 64'(in_ready), 64'(0));

        ncmp = $urandom_range(1, 4);
        for (int i = 0; i < ncmp; i++) begin
            @(posedge clk); #1;
            rand_cmp();
            start    = 1'($urandom);
            cmp_done = (i == ncmp - 1);
            @(negedge clk);
            check("cp_pulse", 64'(cmp_start), 64'(0));
            check("cp_pass", 64'(mem_vec()), 64'(cmp_vec()));
            check("cp_done", 64'(done), 64'(0));
        end

        // DONE cycle with cmp_done held high
        @(posedge clk); #1;
        start = 1'b0;
        rand_cmp();
        @(negedge clk);
        check("dn_done", 64'(done), 64'(1));
        check("dn_mem", 64'(mem_vec()), 64'(0));
        check("dn_busy", 64'(busy), 64'(1));
        check("dn_start", 64'(cmp_start), 64'(0));

        @(posedge clk); #1;
        cmp_done = 1'b0; in_valid = 1'($urandom);
        @(negedge clk);
        check("end_idle", 64'({busy, done, in_ready}), 64'(0));
        check("end_mem", 64'(mem_vec()), 64'(0));
`ifdef NN_MEM_CTRL_LOAD_CHECKSUM_EN
        check("load_ones", 64'(load_ones), 64'(ones));
`else
        check("load_ones", 64'(load_ones), 64'(0));
`endif
    endtask

    // Reset asserted on the 5th weight beat drops everything, including the pending write
    task automatic reset_mid_load();
        @(posedge clk); #1;
        start = 1'b1; len_w = 20'd10; len_x = 10'd8; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b1; in_data = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_flags", 64'({in_ready, busy, done, cmp_start}), 64'(0));
        check("rst_mem", 64'(mem_vec()), 64'(0));
        check("rst_ones", 64'(load_ones), 64'(0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_stay_idle", 64'({busy, in_ready}), 64'(0));
        check("rst_stay_mem", 64'(mem_vec()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len_w = '0; len_x = '0; in_valid = 1'b0; in_data = 1'b0;
        cmp_done = 1'b0;
        rand_cmp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'({in_ready, busy, done, cmp_start}), 64'(0));
        check("reset_mem", 64'(mem_vec()), 64'(0));
        check("reset_ones", 64'(load_ones), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_seq(10, 8, 0);
        run_seq(10, 8, 1);
        run_seq(0, 3, 0);
        run_seq(0, 0, 0);
        run_seq(2, 0, 2);
        reset_mid_load();
        run_seq(10, 8, 0);
        for (int k = 0; k < 8; k++)
            run_seq($urandom_range(0, 5), $urandom_range(0, 6), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
